// File: rtl/count_display_driver_pkg.sv
// Shared definitions for the decimal seven-segment display driver:
// converter FSM states, segment patterns and small helper functions.
package count_display_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } bcd_state_e;

    localparam int BCD_ITER = 8;

    // Segment patterns ordered {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/count_display_driver_bcd_converter_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits in
// LOAD + 8 SHIFT + DONE cycles, with busy covering the whole job.
module bcd_converter_seq
    import count_display_driver_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    bcd_state_e  state_q;
    logic [2:0]  iter_q;
    logic        busy_q;
    logic        done_q;
    logic [19:0] shift_q;
    logic [19:0] adj;
    logic [19:0] shift_d;
    logic [11:0] bcd_q;

    always_comb begin
        adj     = {dabble_adjust(shift_q[19:16]), dabble_adjust(shift_q[15:12]),
                   dabble_adjust(shift_q[11:8]), shift_q[7:0]};
        shift_d = {adj[18:0], 1'b0};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            iter_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    iter_q  <= 3'd0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    iter_q <= iter_q + 3'd1;
                    if (iter_q == 3'(BCD_ITER - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Result is latched together with the final shift so it is stable while done is high.
    always_ff @(posedge clock) begin
        if (state_q == ST_LOAD) begin
            shift_q <= {12'b0, bin};
        end else if (state_q == ST_SHIFT) begin
            shift_q <= shift_d;
        end
        if (state_q == ST_SHIFT && iter_q == 3'(BCD_ITER - 1)) begin
            bcd_q <= shift_d[19:8];
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/count_display_driver.sv
// Shows an 8-bit count in decimal on a 4-digit common-anode display:
// change detection, glitch-free digit registers and the refresh scan.
module count_display_driver
    import count_display_driver_pkg::*;
#(
    parameter int REFRESH_COUNT = 50000,
    parameter int REFRESH_W     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    logic                 start;
    logic                 conv_busy;
    logic                 conv_done;
    logic [11:0]          conv_bcd;
    logic [7:0]           conv_bin;
    logic [7:0]           last_q;
    logic [11:0]          disp_q, disp_d;
    logic [REFRESH_W-1:0] div_q, div_d;
    logic [1:0]           idx_q, idx_d;
    logic [6:0]           seg_q, seg_d;
    logic [3:0]           an_q, an_d;

    assign start = (value != last_q);

    bcd_converter_seq u_conv (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // The value that was actually converted is recovered from its digits, so a
    // mid-conversion change of value is still seen as a mismatch afterwards.
    assign conv_bin = 8'(conv_bcd[11:8]) * 8'd100 + 8'(conv_bcd[7:4]) * 8'd10
                    + 8'(conv_bcd[3:0]);

    always_comb begin
        disp_d = conv_done ? conv_bcd : disp_q;

        if (div_q == REFRESH_W'(REFRESH_COUNT - 1)) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            div_d = div_q + 1'b1;
            idx_d = idx_q;
        end

        an_d  = ~(4'b0001 << idx_d);
        seg_d = SEG_BLANK;
        case (idx_d)
            2'd0: seg_d = seg_encode(disp_d[3:0]);
            2'd1: seg_d = (disp_d[11:4] == 8'd0) ? SEG_BLANK : seg_encode(disp_d[7:4]);
            2'd2: seg_d = (disp_d[11:8] == 4'd0) ? SEG_BLANK : seg_encode(disp_d[11:8]);
            2'd3: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= 8'd0;
            disp_q <= 12'd0;
            div_q  <= '0;
            idx_q  <= 2'd0;
            seg_q  <= SEG_0;
            an_q   <= 4'b1110;
        end else begin
            if (conv_done) begin
                last_q <= conv_bin;
            end
            disp_q <= disp_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;
    assign busy = conv_busy;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: directed scenarios plus random
// value sequences, checked every cycle against a behavioural display model.
module tb_count_display_driver;

    localparam int RC = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: a job countdown, the shown number and the scan position.
    int m_left, m_cap, m_last, m_disp, m_div, m_idx;

    logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    count_display_driver #(.REFRESH_COUNT(RC), .REFRESH_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .an    (an),
        .dp    (dp),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int idx, input int v);
        case (idx)
            0:       return SEG_TAB[v % 10];
            1:       return (v < 10) ? 7'h7f : SEG_TAB[(v / 10) % 10];
            2:       return (v < 100) ? 7'h7f : SEG_TAB[v / 100];
            default: return 7'h7f;
        endcase
    endfunction

    task automatic model_reset();
        m_left = 0; m_cap = 0; m_last = 0; m_disp = 0; m_div = 0; m_idx = 0;
    endtask

    task automatic model_edge();
        if (m_left == 0) begin
            if (int'(value) != m_last) m_left = 10;
        end else begin
            if (m_left == 10) m_cap = int'(value);
            m_left--;
            if (m_left == 0) begin
                m_disp = m_cap;
                m_last = m_cap;
            end
        end
        if (m_div == RC - 1) begin
            m_div = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_div++;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] e_an;
        e_an = 4'b1111 ^ (4'b0001 << m_idx);
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(exp_seg(m_idx, m_disp)));
        chk("dp", 32'(dp), 32'd1);
        chk("busy", 32'(busy), (m_left > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic cyc();
        @(posedge clock);
        if (reset) model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (cycles) cyc();
        reset = 1'b1;
    endtask

    // One full scan, comparing each digit position against literal patterns.
    task automatic scan_expect(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2);
        for (int i = 0; i < 4 * RC; i++) begin
            cyc();
            if (m_div == 0) begin
                case (m_idx)
                    0:       chk({tag, "_d0"}, 32'(seg), 32'(s0));
                    1:       chk({tag, "_d1"}, 32'(seg), 32'(s1));
                    2:       chk({tag, "_d2"}, 32'(seg), 32'(s2));
                    default: chk({tag, "_d3"}, 32'(seg), 32'h7f);
                endcase
            end
        end
    endtask

    initial begin
        int periods;
        logic pb;

        value = 8'd0;
        reset = 1'b1;
        #2;
        do_reset(2);
        repeat (12) cyc();

        value = 8'd255;
        repeat (14) cyc();
        scan_expect("v255", 7'b0010010, 7'b0010010, 7'b0100100);

        value = 8'd7;
        repeat (12) cyc();
        scan_expect("v7", 7'b1111000, 7'b1111111, 7'b1111111);

        value = 8'd105;
        repeat (12) cyc();
        scan_expect("v105", 7'b0010010, 7'b1000000, 7'b1111001);

        value = 8'd100;
        periods = 0;
        pb = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (busy && !pb) periods++;
            pb = busy;
            if (i == 3) value = 8'd200;
        end
        chk("busy_periods", 32'(periods), 32'd2);
        scan_expect("v200", 7'b1000000, 7'b1000000, 7'b0100100);

        value = 8'd42;
        repeat (4) cyc();
        do_reset(2);
        repeat (14) cyc();
        scan_expect("v42", 7'b0100100, 7'b0011001, 7'b1111111);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 14) == 0) begin
                do_reset($urandom_range(1, 3));
            end
            if ($urandom_range(0, 5) != 0) value = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 24)) cyc();
        end
        repeat (30) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
